// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// mem_responder : big-endian byte-serial word memory target (valid/ready)
// Revision      : 1.0
// ============================================================================
module mem_responder #(
  parameter int ADDRESS_SIZE = 11,
  parameter int WORD_SIZE    = 64,
  parameter int MEM_BYTES    = 2048
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    reqValid,
  output logic                    reqReady,
  input  logic                    reqWrite,
  input  logic [ADDRESS_SIZE-1:0] reqAddress,
  input  logic [WORD_SIZE-1:0]    reqWriteData,
  output logic                    respValid,
  input  logic                    respReady,
  output logic [WORD_SIZE-1:0]    respData,
  input  logic [ADDRESS_SIZE-1:0] debugAddress,
  output logic [7:0]              debugOut
);

  localparam int NB    = WORD_SIZE / 8;
  localparam int IDX_W = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [IDX_W-1:0]        index_q, index_d;
  logic                    write_q, write_d;
  logic [ADDRESS_SIZE-1:0] addr_q, addr_d;
  logic [WORD_SIZE-1:0]    wdata_q, wdata_d;
  logic [WORD_SIZE-1:0]    resp_data_q, resp_data_d;
  logic                    resp_valid_q, resp_valid_d;
  logic                    req_ready_q, req_ready_d;
  logic [7:0]              mem_q [MEM_BYTES];

  logic                    mem_we;
  logic [ADDRESS_SIZE-1:0] byte_addr;
  logic [7:0]              xfer_byte;

  // Address arithmetic is ADDRESS_SIZE wide, so it wraps at MEM_BYTES for free.
  assign byte_addr = addr_q + ADDRESS_SIZE'(index_q);
  // The write word is shifted left each byte, so its MSB byte is always the next one out.
  assign xfer_byte = write_q ? wdata_q[WORD_SIZE-1 -: 8] : mem_q[byte_addr];

  always_comb begin
    state_d      = state_q;
    index_d      = index_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_data_d  = resp_data_q;
    resp_valid_d = resp_valid_q;
    req_ready_d  = req_ready_q;
    mem_we       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (reqValid) begin
          state_d     = XFER;
          write_d     = reqWrite;
          addr_d      = reqAddress;
          wdata_d     = reqWriteData;
          index_d     = '0;
          resp_data_d = '0;
          req_ready_d = 1'b0;
        end
      end
      XFER: begin
        mem_we      = write_q;
        wdata_d     = wdata_q << 8;
        resp_data_d = (resp_data_q << 8) | WORD_SIZE'(xfer_byte);
        index_d     = index_q + 1'b1;
        if (index_q == LAST_IDX) begin
          state_d      = RESP;
          index_d      = '0;
          resp_valid_d = 1'b1;
        end
      end
      RESP: begin
        if (respReady) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          req_ready_d  = 1'b1;
        end
      end
      default: begin
        state_d      = IDLE;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      index_q      <= '0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_data_q  <= '0;
      resp_valid_q <= 1'b0;
      req_ready_q  <= 1'b1;
      for (int i = 0; i < MEM_BYTES; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      state_q      <= state_d;
      index_q      <= index_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_data_q  <= resp_data_d;
      resp_valid_q <= resp_valid_d;
      req_ready_q  <= req_ready_d;
      if (mem_we) begin
        mem_q[byte_addr] <= xfer_byte;
      end
    end
  end

  assign reqReady  = req_ready_q;
  assign respValid = resp_valid_q;
  assign respData  = resp_data_q;
  assign debugOut  = mem_q[debugAddress];

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_mem_responder : randomized bench with a byte-array reference model
// Revision         : 1.0
// ============================================================================
module tb_mem_responder;

  localparam int NB = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        reqValid = 1'b0;
  logic        reqReady;
  logic        reqWrite = 1'b0;
  logic [10:0] reqAddress = '0;
  logic [63:0] reqWriteData = '0;
  logic        respValid;
  logic        respReady = 1'b0;
  logic [63:0] respData;
  logic [10:0] debugAddress = '0;
  logic [7:0]  debugOut;

  int n_checks = 0;
  int n_fail   = 0;
  bit dbg_rand = 1'b0;

  mem_responder dut (
    .clk          (clk),
    .reset        (reset),
    .reqValid     (reqValid),
    .reqReady     (reqReady),
    .reqWrite     (reqWrite),
    .reqAddress   (reqAddress),
    .reqWriteData (reqWriteData),
    .respValid    (respValid),
    .respReady    (respReady),
    .respData     (respData),
    .debugAddress (debugAddress),
    .debugOut     (debugOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain byte array plus "busy / response pending" bookkeeping.
  logic [7:0]  m_mem [2048];
  bit          m_busy, m_pend, m_resp_known, m_started;
  int          m_cnt;
  bit          m_wr;
  logic [10:0] m_addr;
  logic [63:0] m_wdata, m_resp;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 2048; i++) m_mem[i] = 8'h00;
      m_busy = 0; m_pend = 0; m_cnt = 0; m_resp = '0; m_resp_known = 1; m_started = 1;
    end else if (!m_busy) begin
      if (reqValid) begin
        m_busy = 1; m_cnt = 0; m_wr = reqWrite; m_addr = reqAddress; m_wdata = reqWriteData;
        m_resp_known = 0;
      end
    end else if (!m_pend) begin
      if (m_wr) m_mem[(int'(m_addr) + m_cnt) % 2048] = m_wdata[63 - 8*m_cnt -: 8];
      m_cnt++;
      if (m_cnt == NB) begin
        m_pend = 1;
        if (m_wr) m_resp = m_wdata;
        else for (int k = 0; k < NB; k++) m_resp = {m_resp[55:0], m_mem[(int'(m_addr) + k) % 2048]};
        m_resp_known = 1;
      end
    end else if (respReady) begin
      m_busy = 0; m_pend = 0;
    end
  end

  always @(negedge clk) begin
    if (m_started) begin
      chk("reqReady", {63'd0, reqReady}, {63'd0, !m_busy});
      chk("respValid", {63'd0, respValid}, {63'd0, m_pend});
      chk("debugOut", {56'd0, debugOut}, {56'd0, m_mem[debugAddress]});
      if (m_resp_known) chk("respData", respData, m_resp);
    end
  end

  task automatic issue(input bit wr, input logic [10:0] a, input logic [63:0] d);
    int n;
    n = 0;
    @(posedge clk); #1;
    reqValid = 1; reqWrite = wr; reqAddress = a; reqWriteData = d;
    @(negedge clk);
    while (!reqReady && n < 100) begin @(negedge clk); n++; end
    if (!reqReady) chk("accept_timeout", 64'd1, 64'd0);
    @(posedge clk); #1;
    reqValid = 0; reqWrite = 1'($urandom); reqAddress = 11'($urandom);
    reqWriteData = {$urandom, $urandom};
  endtask

  task automatic wait_resp();
    int lat;
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      if (dbg_rand) debugAddress = 11'($urandom_range(0, 2047));
      @(negedge clk);
    end while (!respValid && lat < 100);
    chk("latency", 64'(lat), 64'd8);
  endtask

  task automatic complete(input int hold, output logic [63:0] rdata);
    repeat (hold) @(posedge clk);
    #1 respReady = 1;
    @(negedge clk); rdata = respData;
    @(posedge clk); #1 respReady = 0;
  endtask

  task automatic xact(input bit wr, input logic [10:0] a, input logic [63:0] d,
                      input int hold, output logic [63:0] rdata);
    issue(wr, a, d);
    wait_resp();
    complete(hold, rdata);
  endtask

  task automatic dbg(input logic [10:0] a, input logic [7:0] exp, input string nm);
    debugAddress = a; #1;
    chk(nm, {56'd0, debugOut}, {56'd0, exp});
  endtask

  initial begin
    logic [63:0] r;
    logic [10:0] a;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_reqReady", {63'd0, reqReady}, 64'd1);
    chk("rst_respValid", {63'd0, respValid}, 64'd0);
    chk("rst_respData", respData, 64'd0);
    for (int i = 0; i < 2048; i++) dbg(11'(i), 8'h00, "rst_sweep");

    xact(1, 11'd8, 64'h0011223344556677, 0, r);
    chk("wr8_echo", r, 64'h0011223344556677);
    xact(0, 11'd8, 64'h0, 1, r);
    chk("rd8", r, 64'h0011223344556677);
    dbg(11'd8, 8'h00, "dbg8");
    dbg(11'd15, 8'h77, "dbg15");

    xact(1, 11'd2044, 64'hAABBCCDDEEFF0102, 2, r);
    dbg(11'd0, 8'hEE, "wrap_dbg0");
    dbg(11'd2047, 8'hDD, "wrap_dbg2047");
    dbg(11'd3, 8'h02, "wrap_dbg3");
    xact(0, 11'd2044, 64'h0, 0, r);
    chk("wrap_rd", r, 64'hAABBCCDDEEFF0102);

    // Response held off while a new request waits at the input.
    issue(0, 11'd2044, 64'h0);
    wait_resp();
    #1; reqValid = 1; reqWrite = 0; reqAddress = 11'd8;
    complete(5, r);
    chk("hold_rd", r, 64'hAABBCCDDEEFF0102);
    @(negedge clk);
    chk("b2b_ready", {63'd0, reqReady}, 64'd1);
    @(posedge clk); #1 reqValid = 0;
    wait_resp();
    complete(0, r);
    chk("b2b_rd", r, 64'h0011223344556677);

    // Reset on the 4th transfer cycle of a write.
    issue(1, 11'd100, 64'hFFFFFFFFFFFFFFFF);
    repeat (3) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    for (int i = 0; i < 8; i++) dbg(11'(100 + i), 8'h00, "abort_dbg");
    dbg(11'd15, 8'h00, "abort_dbg15");
    repeat (3) @(negedge clk);
    chk("abort_noresp", {63'd0, respValid}, 64'd0);
    xact(1, 11'd100, 64'h123456789ABCDEF0, 0, r);
    xact(0, 11'd100, 64'h0, 0, r);
    chk("abort_next", r, 64'h123456789ABCDEF0);

    xact(1, 11'd0, 64'h0102030405060708, 0, r);
    xact(1, 11'd8, 64'h090A0B0C0D0E0F10, 0, r);
    xact(0, 11'd3, 64'h0, 0, r);
    chk("misaligned", r, 64'h0405060708090A0B);

    dbg_rand = 1;
    for (int t = 0; t < 40; t++) begin
      a = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(2040, 2047)) : 11'($urandom_range(0, 2047));
      xact(1'($urandom), a, {$urandom, $urandom}, $urandom_range(0, 3), r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
